// File: rtl/chroma_pkg.sv
// Shared definitions for the chroma-key path: reset nominals, calibrator states
// and XVGA frame geometry.
package chroma_pkg;

    // Nominal key values used until a calibration publishes new ones
    localparam logic [7:0] H_NOMINAL = 8'd85;
    localparam logic [7:0] S_NOMINAL = 8'd94;
    localparam logic [7:0] V_NOMINAL = 8'd202;

    // XVGA 1024x768 frame geometry (pixel clock units)
    localparam int unsigned XVGA_H_ACTIVE = 1024;
    localparam int unsigned XVGA_H_FP     = 24;
    localparam int unsigned XVGA_H_SYNC   = 136;
    localparam int unsigned XVGA_H_BP     = 160;
    localparam int unsigned XVGA_H_TOTAL  = 1344;
    localparam int unsigned XVGA_V_ACTIVE = 768;
    localparam int unsigned XVGA_V_FP     = 3;
    localparam int unsigned XVGA_V_SYNC   = 6;
    localparam int unsigned XVGA_V_BP     = 29;
    localparam int unsigned XVGA_V_TOTAL  = 806;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StAccum,
        StDone
    } cal_state_t;

    // True when lo <= pos < lo + len
    function automatic logic in_span(input int unsigned pos, input int unsigned lo,
                                     input int unsigned len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/chroma_chan_accum.sv
// One colour channel of the calibrator: sums window samples and exposes the
// mean of a full window (sum divided by the power-of-two sample count).
module chroma_chan_accum #(
    parameter int unsigned WIN_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] mean
);

    // Wide enough for 2^(2*WIN_LOG2) samples of 255 without overflow
    localparam int unsigned ACC_W = 8 + 2 * WIN_LOG2;

    logic [ACC_W-1:0] acc_q;

    // Running sum, cleared at the start of each calibration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + {{(2 * WIN_LOG2){1'b0}}, din};
        end
    end

    // Dividing by the sample count is just taking the top byte
    assign mean = acc_q[ACC_W-1 -: 8];

endmodule

// File: rtl/chroma_calibrator.sv
// Chroma-key auto-calibration: on a start request, averages H/S/V over a fixed
// square window for one full frame and publishes the means as new nominals.
module chroma_calibrator
    import chroma_pkg::*;
#(
    parameter int unsigned WIN_X    = 504,
    parameter int unsigned WIN_Y    = 376,
    parameter int unsigned WIN_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [23:0] hsv_in,
    input  logic        start,
    output logic [7:0]  h_nom,
    output logic [7:0]  s_nom,
    output logic [7:0]  v_nom,
    output logic        busy,
    output logic        cal_valid,
    output logic        cal_err
);

    localparam int unsigned SIDE  = 1 << WIN_LOG2;
    localparam int unsigned CNT_W = 2 * WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {(2 * WIN_LOG2){1'b0}}};

    cal_state_t       state_q, state_d;
    logic             start_q, vsync_q;
    logic             start_rise, vsync_fall;
    logic             in_win;
    logic [CNT_W-1:0] cnt_q;
    logic             acc_clr, acc_en, publish, reject;
    logic [7:0]       h_mean, s_mean, v_mean;
    logic [7:0]       h_nom_q, s_nom_q, v_nom_q;
    logic             cal_valid_q, cal_err_q;

    assign start_rise = start & ~start_q;
    assign vsync_fall = vsync_q & ~vsync;
    assign in_win     = in_span({21'd0, hcount}, WIN_X, SIDE) &&
                        in_span({22'd0, vcount}, WIN_Y, SIDE);

    // Registered copies of start and vsync for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            vsync_q <= 1'b1;
        end else begin
            start_q <= start;
            vsync_q <= vsync;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start edges outside IDLE are simply dropped
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_rise) state_d = StArm;
            StArm:   if (vsync_fall) state_d = StAccum;
            StAccum: if (vsync_fall) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; the pixel on the vsync-fall cycle is blanking and is skipped
    always_comb begin
        busy    = (state_q != StIdle);
        acc_clr = (state_q == StIdle) && start_rise;
        acc_en  = (state_q == StAccum) && in_win && !vsync_fall;
        publish = (state_q == StDone) && (cnt_q == CNT_FULL);
        reject  = (state_q == StDone) && (cnt_q != CNT_FULL);
    end

    // Saturating sample counter so a runaway window cannot wrap back to a match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (acc_clr) begin
            cnt_q <= '0;
        end else if (acc_en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    chroma_chan_accum #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_h_accum (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .en   (acc_en),
        .din  (hsv_in[23:16]),
        .mean (h_mean)
    );

    chroma_chan_accum #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_s_accum (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .en   (acc_en),
        .din  (hsv_in[15:8]),
        .mean (s_mean)
    );

    chroma_chan_accum #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_v_accum (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .en   (acc_en),
        .din  (hsv_in[7:0]),
        .mean (v_mean)
    );

    // Result registers: nominals change only on a complete window, pulses last one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_nom_q     <= H_NOMINAL;
            s_nom_q     <= S_NOMINAL;
            v_nom_q     <= V_NOMINAL;
            cal_valid_q <= 1'b0;
            cal_err_q   <= 1'b0;
        end else begin
            if (publish) begin
                h_nom_q <= h_mean;
                s_nom_q <= s_mean;
                v_nom_q <= v_mean;
            end
            cal_valid_q <= publish;
            cal_err_q   <= reject;
        end
    end

    assign h_nom     = h_nom_q;
    assign s_nom     = s_nom_q;
    assign v_nom     = v_nom_q;
    assign cal_valid = cal_valid_q;
    assign cal_err   = cal_err_q;

endmodule

// File: tb/tb_chroma_calibrator.sv
// Directed + randomized bench for chroma_calibrator. Two instances share the
// stimulus: one with the default window, one with the window off-screen.
module tb_chroma_calibrator;

    localparam int WX   = 504;
    localparam int WY   = 376;
    localparam int WL   = 4;
    localparam int SIDE = 16;
    localparam int WX2  = 2000;
    localparam int NSMP = SIDE * SIDE;

    logic        clk = 1'b0;
    logic        rst, vsync, start;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [23:0] hsv_in;
    logic [7:0]  h0, s0, v0, h1, s1, v1;
    logic        busy0, cv0, ce0, busy1, cv1, ce1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chroma_calibrator #(.WIN_X(WX), .WIN_Y(WY), .WIN_LOG2(WL)) dut0 (
        .clk(clk), .rst(rst), .vsync(vsync), .hcount(hcount), .vcount(vcount),
        .hsv_in(hsv_in), .start(start), .h_nom(h0), .s_nom(s0), .v_nom(v0),
        .busy(busy0), .cal_valid(cv0), .cal_err(ce0)
    );

    chroma_calibrator #(.WIN_X(WX2), .WIN_Y(WY), .WIN_LOG2(WL)) dut1 (
        .clk(clk), .rst(rst), .vsync(vsync), .hcount(hcount), .vcount(vcount),
        .hsv_in(hsv_in), .start(start), .h_nom(h1), .s_nom(s1), .v_nom(v1),
        .busy(busy1), .cal_valid(cv1), .cal_err(ce1)
    );

    // Pulse monitor: counts pulses, remembers when they happened, flags overlaps
    int mon_valid [2] = '{0, 0};
    int mon_err   [2] = '{0, 0};
    int mon_last  [2] = '{-1, -1};
    int mon_viol  [2] = '{0, 0};
    always @(negedge clk) begin
        if (!rst) begin
            if (cv0 || ce0) begin
                mon_last[0] = cyc;
                if (cv0) mon_valid[0]++;
                if (ce0) mon_err[0]++;
                if ((cv0 && ce0) || busy0) mon_viol[0]++;
            end
            if (cv1 || ce1) begin
                mon_last[1] = cyc;
                if (cv1) mon_valid[1]++;
                if (ce1) mon_err[1]++;
                if ((cv1 && ce1) || busy1) mon_viol[1]++;
            end
        end
    end

    // Reference model: per instance, idle/armed/collecting plus window sums
    int          m_phase [2];
    int          m_cnt   [2];
    int          m_sum_h [2], m_sum_s [2], m_sum_v [2];
    logic [23:0] m_nom   [2];
    int          m_valid [2], m_err [2], m_last [2];
    int          m_wx    [2] = '{WX, WX2};
    bit          busy_pending = 1'b0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0;
            m_nom[d]   = {8'd85, 8'd94, 8'd202};
        end
    endtask

    task automatic model_start();
        for (int d = 0; d < 2; d++) begin
            if (m_phase[d] == 0) begin
                m_phase[d] = 1;
                busy_pending = 1'b1;
            end
        end
    endtask

    task automatic model_fall();
        for (int d = 0; d < 2; d++) begin
            if (m_phase[d] == 1) begin
                m_phase[d] = 2;
                m_cnt[d] = 0; m_sum_h[d] = 0; m_sum_s[d] = 0; m_sum_v[d] = 0;
            end else if (m_phase[d] == 2) begin
                m_phase[d] = 0;
                m_last[d]  = cyc + 2;
                if (m_cnt[d] == NSMP) begin
                    m_valid[d]++;
                    m_nom[d] = {8'(m_sum_h[d] / NSMP), 8'(m_sum_s[d] / NSMP),
                                8'(m_sum_v[d] / NSMP)};
                end else begin
                    m_err[d]++;
                end
            end
        end
    endtask

    task automatic model_pixel(input int h, input int v, input logic [23:0] p);
        for (int d = 0; d < 2; d++) begin
            if (m_phase[d] == 2 && h >= m_wx[d] && h < m_wx[d] + SIDE &&
                v >= WY && v < WY + SIDE) begin
                m_cnt[d]++;
                m_sum_h[d] += int'(p[23:16]);
                m_sum_s[d] += int'(p[15:8]);
                m_sum_v[d] += int'(p[7:0]);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int pat, input int h, input int v);
        bit inwin;
        inwin = (h >= WX) && (h < WX + SIDE) && (v >= WY) && (v < WY + SIDE);
        case (pat)
            0:       return {8'd100, 8'd150, 8'd200};
            1:       return !inwin ? 24'hFFFFFF :
                            ((h % 2) == 0 ? {8'd0, 8'd10, 8'd0} : {8'd255, 8'd20, 8'd1});
            default: return 24'($urandom);
        endcase
    endfunction

    // One mini frame: optional 4-cycle vsync low, then a raster around the window.
    // The vsync-fall cycle carries a bright in-window pixel that must be ignored.
    task automatic frame(input int pat, input int start_at, input int npix, input bit do_vs);
        int idx;
        if (do_vs) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                vsync = 1'b0;
                if (i == 0) begin
                    hcount = 11'(WX); vcount = 10'(WY); hsv_in = 24'hFFFFFF;
                    model_fall();
                end else begin
                    hcount = '0; vcount = '0; hsv_in = 24'($urandom);
                end
            end
        end
        idx = 0;
        for (int v = WY - 3; v < WY + SIDE + 3; v++) begin
            for (int h = WX - 4; h < WX + SIDE + 4; h++) begin
                if (npix >= 0 && idx >= npix) return;
                @(negedge clk);
                if (busy_pending) begin
                    chk("busy_rise0", 32'(busy0), 32'd1);
                    chk("busy_rise1", 32'(busy1), 32'd1);
                    busy_pending = 1'b0;
                end
                vsync  = 1'b1;
                hcount = 11'(h);
                vcount = 10'(v);
                hsv_in = pix(pat, h, v);
                if (idx == start_at) begin
                    start = 1'b1;
                    model_start();
                end
                if (idx == start_at + 3) start = 1'b0;
                model_pixel(h, v, hsv_in);
                idx++;
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_valid_cnt0"}, 32'(mon_valid[0]), 32'(m_valid[0]));
        chk({tag, "_err_cnt0"},   32'(mon_err[0]),   32'(m_err[0]));
        chk({tag, "_last0"},      32'(mon_last[0]),  32'(m_last[0]));
        chk({tag, "_nom0"},       32'({h0, s0, v0}), 32'(m_nom[0]));
        chk({tag, "_busy0"},      32'(busy0),        32'(m_phase[0] != 0));
        chk({tag, "_viol0"},      32'(mon_viol[0]),  32'd0);
        chk({tag, "_valid_cnt1"}, 32'(mon_valid[1]), 32'(m_valid[1]));
        chk({tag, "_err_cnt1"},   32'(mon_err[1]),   32'(m_err[1]));
        chk({tag, "_last1"},      32'(mon_last[1]),  32'(m_last[1]));
        chk({tag, "_nom1"},       32'({h1, s1, v1}), 32'(m_nom[1]));
        chk({tag, "_busy1"},      32'(busy1),        32'(m_phase[1] != 0));
        chk({tag, "_viol1"},      32'(mon_viol[1]),  32'd0);
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; start = 1'b0;
        hcount = '0; vcount = '0; hsv_in = '0;
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0; m_err[d] = 0; m_last[d] = -1;
            m_cnt[d] = 0; m_sum_h[d] = 0; m_sum_s[d] = 0; m_sum_v[d] = 0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_state("reset");
        chk("reset_cv0", 32'(cv0), 32'd0);
        chk("reset_ce0", 32'(ce0), 32'd0);
        chk("reset_h0", 32'(h0), 32'd85);
        chk("reset_s0", 32'(s0), 32'd94);
        chk("reset_v0", 32'(v0), 32'd202);
        rst = 1'b0;
        frame(0, -1, -1, 1'b1);

        // Constant pixels: nominals become the constant
        frame(0, 20, -1, 1'b1);
        check_state("t1_arm");
        frame(0, -1, -1, 1'b1);
        frame(0, -1, -1, 1'b1);
        check_state("t1_done");
        chk("t1_h", 32'(h0), 32'd100);
        chk("t1_s", 32'(s0), 32'd150);
        chk("t1_v", 32'(v0), 32'd200);
        chk("t5_offscreen_err", 32'(mon_err[1]), 32'd1);
        chk("t5_offscreen_valid", 32'(mon_valid[1]), 32'd0);

        // Alternating window pixels, saturated surround
        frame(1, 20, -1, 1'b1);
        frame(1, -1, -1, 1'b1);
        frame(1, -1, -1, 1'b1);
        check_state("t2_done");
        chk("t2_h", 32'(h0), 32'd127);
        chk("t2_s", 32'(s0), 32'd15);
        chk("t2_v", 32'(v0), 32'd0);

        // Random pixels with a second start during accumulation
        frame(2, 20, -1, 1'b1);
        frame(2, 50, -1, 1'b1);
        frame(2, -1, -1, 1'b1);
        check_state("t3_done");
        frame(2, -1, -1, 1'b1);
        check_state("t3_quiet");

        // Reset in the middle of accumulation, then a clean calibration
        frame(2, 20, -1, 1'b1);
        frame(2, -1, 200, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk("t4_busy0", 32'(busy0), 32'd0);
        chk("t4_nom0", 32'({h0, s0, v0}), 32'h555ECA);
        chk("t4_nom1", 32'({h1, s1, v1}), 32'h555ECA);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        frame(2, 20, -1, 1'b1);
        frame(2, -1, -1, 1'b1);
        frame(2, -1, -1, 1'b1);
        check_state("t4_done");

        // Start with vsync held high: stays armed, in-window pixels ignored
        frame(2, 20, -1, 1'b0);
        frame(2, -1, -1, 1'b0);
        frame(2, -1, -1, 1'b0);
        check_state("t6_armed");
        frame(2, -1, -1, 1'b1);
        frame(2, -1, -1, 1'b1);
        check_state("t6_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
